// File: rtl/mini_src_pkg.sv
// Shared definitions for the MAR/MDR memory data unit: default widths,
// default timeout and the transaction sequencer state encoding.
package mini_src_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mem_data_unit_if.sv
// Single-word RAM handshake between the memory data unit (master) and
// the RAM (slave). Requests are held until mem_ready or abort.
interface mem_data_unit_if
  import mini_src_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_rd,
    output mem_wr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_rd,
    input  mem_wr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mdu_timeout_ctr.sv
// Wait-state counter for memory transactions. Clears on request, counts
// cycles without mem_ready and saturates at TIMEOUT, flagging expiry.
module mdu_timeout_ctr
  import mini_src_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;

  assign expired = (cnt_r == CW'(TIMEOUT));

  // Count waiting cycles; hold once TIMEOUT is reached so it never wraps.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mem_data_unit.sv
// MAR/MDR pair on the datapath bus plus the single-word RAM read/write
// sequencer behind them, with a wait-state timeout abort.
module mem_data_unit
  import mini_src_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_start,
  input  logic              wr_start,
  mem_data_unit_if.master   mem,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mdu_state_t        state_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] mdr_r;
  logic              rd_r;
  logic              wr_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              ctr_clear_s;
  logic              ctr_en_s;
  logic              expired_s;

  assign mem.mem_addr  = mar_r;
  assign mem.mem_wdata = mdr_r;
  assign mem.mem_rd    = rd_r;
  assign mem.mem_wr    = wr_r;
  assign mdr_q         = mdr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

  // Counter runs only while a request is outstanding; anywhere else it is held at zero.
  always_comb begin
    ctr_clear_s = 1'b1;
    ctr_en_s    = 1'b0;
    if ((state_r == RD) || (state_r == WR)) begin
      ctr_clear_s = 1'b0;
      ctr_en_s    = !mem.mem_ready;
    end else begin
      ctr_clear_s = 1'b1;
      ctr_en_s    = 1'b0;
    end
  end

  mdu_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .clr     (clr),
    .clear   (ctr_clear_s),
    .enable  (ctr_en_s),
    .expired (expired_s)
  );

  // Sequencer with MAR/MDR: loads only in IDLE, so address/data stay stable during a request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      mar_r   <= '0;
      mdr_r   <= '0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mar_in) begin
            mar_r <= bus_in[ADDR_W-1:0];
          end
          if (mdr_in) begin
            mdr_r <= bus_in;
          end
          // Read has priority; a simultaneous write start is discarded.
          if (rd_start) begin
            state_r <= RD;
            rd_r    <= 1'b1;
            busy_r  <= 1'b1;
          end else if (wr_start) begin
            state_r <= WR;
            wr_r    <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RD, WR: begin
          // Ready beats a coincident timeout.
          if (mem.mem_ready) begin
            if (state_r == RD) begin
              mdr_r <= mem.mem_rdata;
            end
            state_r <= RESP;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            done_r  <= 1'b1;
          end else if (expired_s) begin
            state_r <= RESP;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            done_r  <= 1'b1;
            err_r   <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        RESP: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          rd_r    <= 1'b0;
          wr_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_unit.sv
// Self-checking bench for mem_data_unit: directed transactions with a
// scoreboard of expected completions checked whenever done pulses.
module tb_mem_data_unit;

  logic        clk;
  logic        clr;
  logic [31:0] bus_in;
  logic        mar_in;
  logic        mdr_in;
  logic        rd_start;
  logic        wr_start;
  logic [31:0] mdr_q;
  logic        busy;
  logic        done;
  logic        err;

  mem_data_unit_if #(.DATA_W(32), .ADDR_W(9)) mif ();

  mem_data_unit #(
    .DATA_W  (32),
    .ADDR_W  (9),
    .TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .bus_in   (bus_in),
    .mar_in   (mar_in),
    .mdr_in   (mdr_in),
    .rd_start (rd_start),
    .wr_start (wr_start),
    .mem      (mif),
    .mdr_q    (mdr_q),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [31:0] mdr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cycles = 0;
  logic [31:0] model_mdr = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse retires one expected completion.
  always @(negedge clk) begin
    if (!clr) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_mdr", mdr_q, e.mdr);
          chk("done_err", 32'(err), 32'(e.err));
        end
      end
      if (mif.mem_wr) wr_cycles++;
    end
  end

  initial begin
    clr = 1'b1; bus_in = 32'd0; mar_in = 1'b0; mdr_in = 1'b0;
    rd_start = 1'b0; wr_start = 1'b0;
    mif.mem_ready = 1'b0; mif.mem_rdata = 32'd0;
    tick(); tick();
    clr = 1'b0;
    tick();
    chk("rst_addr", 32'(mif.mem_addr), 32'd0);
    chk("rst_mdr", mdr_q, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(mif.mem_rd), 32'd0);

    // Bus loads
    bus_in = 32'h0000_01A5; mar_in = 1'b1; tick(); mar_in = 1'b0;
    bus_in = 32'hDEAD_BEEF; mdr_in = 1'b1; tick(); mdr_in = 1'b0;
    model_mdr = 32'hDEAD_BEEF;
    chk("load_mar", 32'(mif.mem_addr), 32'h0000_01A5);
    chk("load_mdr", mdr_q, 32'hDEAD_BEEF);

    // Zero-wait read at 0x010
    bus_in = 32'h0000_0010; mar_in = 1'b1; tick(); mar_in = 1'b0;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("zw_rd", 32'(mif.mem_rd), 32'd1);
    chk("zw_busy", 32'(busy), 32'd1);
    chk("zw_addr", 32'(mif.mem_addr), 32'h0000_0010);
    chk("zw_done_early", 32'(done), 32'd0);
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'h1234_5678;
    exp_q.push_back('{mdr: 32'h1234_5678, err: 1'b0});
    model_mdr = 32'h1234_5678;
    tick(); mif.mem_ready = 1'b0;
    chk("zw_mdr", mdr_q, 32'h1234_5678);
    chk("zw_done", 32'(done), 32'd1);
    chk("zw_rd_drop", 32'(mif.mem_rd), 32'd0);
    tick();
    chk("zw_done_once", 32'(done), 32'd0);
    chk("zw_idle", 32'(busy), 32'd0);

    // Write with 3 wait states; loads during the wait must be ignored
    bus_in = 32'h0000_0020; mar_in = 1'b1; tick(); mar_in = 1'b0;
    bus_in = 32'hCAFE_0001; mdr_in = 1'b1; tick(); mdr_in = 1'b0;
    model_mdr = 32'hCAFE_0001;
    wr_cycles = 0;
    wr_start = 1'b1; tick(); wr_start = 1'b0;
    exp_q.push_back('{mdr: model_mdr, err: 1'b0});
    for (int i = 0; i < 3; i++) begin
      chk("wr_held", 32'(mif.mem_wr), 32'd1);
      chk("wr_wdata", mif.mem_wdata, 32'hCAFE_0001);
      chk("wr_addr", 32'(mif.mem_addr), 32'h0000_0020);
      bus_in = 32'hFFFF_FFFF; mar_in = 1'b1; mdr_in = 1'b1;
      tick();
    end
    mar_in = 1'b0; mdr_in = 1'b0;
    chk("wr_held_last", 32'(mif.mem_wr), 32'd1);
    chk("wr_wdata_last", mif.mem_wdata, 32'hCAFE_0001);
    mif.mem_ready = 1'b1;
    tick(); mif.mem_ready = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_drop", 32'(mif.mem_wr), 32'd0);
    tick();
    chk("wr_done_once", 32'(done), 32'd0);
    chk("wr_cycles", 32'(wr_cycles), 32'd4);
    chk("wr_addr_kept", 32'(mif.mem_addr), 32'h0000_0020);

    // Timeout abort: no ready for 16 edges after entry
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    exp_q.push_back('{mdr: model_mdr, err: 1'b1});
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_wait_done", 32'(done), 32'd0);
      chk("to_wait_rd", 32'(mif.mem_rd), 32'd1);
    end
    tick();
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_mdr", mdr_q, model_mdr);
    chk("to_rd_drop", 32'(mif.mem_rd), 32'd0);
    tick();
    chk("to_err_once", 32'(err), 32'd0);
    tick();

    // Ready on the timeout edge itself wins
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'hA5A5_5A5A;
    exp_q.push_back('{mdr: 32'hA5A5_5A5A, err: 1'b0});
    model_mdr = 32'hA5A5_5A5A;
    tick(); mif.mem_ready = 1'b0;
    chk("tor_done", 32'(done), 32'd1);
    chk("tor_err", 32'(err), 32'd0);
    tick(); tick();

    // Simultaneous rd_start + wr_start + mar_in
    wr_cycles = 0;
    bus_in = 32'h0000_00FF; mar_in = 1'b1; rd_start = 1'b1; wr_start = 1'b1;
    tick();
    mar_in = 1'b0; rd_start = 1'b0; wr_start = 1'b0;
    chk("sim_rd", 32'(mif.mem_rd), 32'd1);
    chk("sim_wr", 32'(mif.mem_wr), 32'd0);
    chk("sim_addr", 32'(mif.mem_addr), 32'h0000_00FF);
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'h0BAD_F00D;
    exp_q.push_back('{mdr: 32'h0BAD_F00D, err: 1'b0});
    model_mdr = 32'h0BAD_F00D;
    tick(); mif.mem_ready = 1'b0;
    tick(); tick();
    chk("sim_no_wr", 32'(wr_cycles), 32'd0);

    // Async clear in the middle of a read
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    tick(); tick();
    chk("mid_rd", 32'(mif.mem_rd), 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_rd_async", 32'(mif.mem_rd), 32'd0);
    chk("clr_mar", 32'(mif.mem_addr), 32'd0);
    chk("clr_mdr", mdr_q, 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    tick();
    clr = 1'b0;
    tick();
    chk("post_clr_idle", 32'(busy), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
